axi_lite_cmd_master: RTL and testbench
======================================

// Module: axi_lite_cmd_master
// PURPOSE
//  Upstream AXI4-Lite master: turns one-at-a-time register commands (from a CPU/UART/debug front end) into single
//  AXI4-Lite read or write transactions that drive our axi4_lite register slave. Returns one response per command.
//  Adds a transaction watchdog so a hung slave cannot stall the command source forever.
// PARAMETERS
//  ADDRESS_SIZE    32    AXI/command address width
//  DATA_SIZE       32    data width; multiple of 8; strobe width DATA_SIZE/8
//  TIMEOUT_CYCLES  1024  watchdog limit in aclk cycles per transaction; 0 disables watchdog
// PORTS
//  aclk                    in   1    clock, all logic on rising edge
//  aresetn                 in   1    synchronous, active-low reset
//  cmd_valid / cmd_ready   in/out 1  command handshake
//  cmd_write               in   1    1 = write, 0 = read
//  cmd_addr                in   ADDRESS_SIZE  byte address
//  cmd_wdata               in   DATA_SIZE     write data (ignored for reads)
//  cmd_wstrb               in   DATA_SIZE/8   byte strobes (ignored for reads)
//  rsp_valid / rsp_ready   out/in 1  response handshake
//  rsp_rdata               out  DATA_SIZE     read data; 0 for writes and timeouts
//  rsp_resp                out  2    BRESP/RRESP as returned; 2'b11 on timeout
//  rsp_timeout             out  1    1 = transaction aborted by watchdog
//  m_axi_awaddr            out  ADDRESS_SIZE
//  m_axi_awvalid/awready   out/in 1
//  m_axi_wdata             out  DATA_SIZE
//  m_axi_wstrb             out  DATA_SIZE/8
//  m_axi_wvalid/wready     out/in 1
//  m_axi_bresp             in   2
//  m_axi_bvalid/bready     in/out 1
//  m_axi_araddr            out  ADDRESS_SIZE
//  m_axi_arvalid/arready   out/in 1
//  m_axi_rdata             in   DATA_SIZE
//  m_axi_rresp             in   2
//  m_axi_rvalid/rready     in/out 1
// BEHAVIOUR
//  Reset: state IDLE; all valids, bready, rready, cmd_ready, rsp_valid, rsp_timeout = 0; addr/data/resp regs = 0.
//   cmd_ready rises the first cycle after aresetn releases. All outputs registered.
//  FSM: IDLE -> WR (cmd_write=1) or RD (cmd_write=0) -> WRESP / RDATA -> RSP -> IDLE.
//  IDLE: cmd_ready=1. On cmd_valid&cmd_ready capture addr/wdata/wstrb, drop cmd_ready; AXI valid(s) high next cycle.
//  WR: awvalid and wvalid assert in the same cycle; each drops the cycle after its own handshake, independently
//   (AW before W, W before AW, same cycle all legal). Once both have completed -> WRESP with bready=1.
//  WRESP: on bvalid&bready latch bresp, bready drops -> RSP.
//  RD: arvalid=1 until arready -> RDATA with rready=1. RDATA: on rvalid latch rdata/rresp, rready drops -> RSP.
//  RSP: rsp_valid=1, payload stable until rsp_ready; on handshake -> IDLE, cmd_ready=1 the next cycle.
//  Min latency (slave ready=1 every cycle): cmd accept @0, valid @1, B/R handshake @2, rsp_valid @3.
//  AXI valids never drop before their ready (except watchdog). Payloads never change while valid is high.
//  Only one outstanding transaction; no pipelining; cmd_valid ignored outside IDLE.
//  Watchdog: counter clears on command accept, increments every cycle in WR/WRESP/RD/RDATA. When it reaches
//   TIMEOUT_CYCLES: drop all AXI valids/readies, rsp_resp=2'b11, rsp_timeout=1, rsp_rdata=0 -> RSP.
//   Timeout is fatal for the bus; the system must pulse aresetn before further use. Not counted in RSP.
//  Handshake completing in the same cycle the counter expires: the handshake wins, no timeout.
//  Reset mid-transaction: aborts immediately, no response produced, all outputs return to reset values.
//  Error responses (SLVERR/DECERR) from the slave are passed through unchanged, rsp_timeout=0.
// STRUCTURE
//  Shared package/header: state encoding localparams, AXI resp constants (OKAY 2'b00, EXOKAY, SLVERR, DECERR).
//  Single module, no sub-modules; watchdog counter inline, width $clog2(TIMEOUT_CYCLES+1).
// TESTING
//  Write 0x0 data 0xDEADBEEF strb 0xF, slave always ready -> one AW+W beat, rsp_valid @cycle 3, resp 00; read-back 0xDEADBEEF.
//  Write with awready delayed 4 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 5, single bresp.
//  Read with rvalid delayed 7 cycles, rresp=10 -> rsp_rdata latched, rsp_resp=10, rsp_timeout=0.
//  TIMEOUT_CYCLES=16, slave never asserts arready -> arvalid drops at count 16, rsp_resp=11, rsp_timeout=1.
//  rsp_ready held low 10 cycles -> response stable, cmd_ready stays 0, no new AXI activity; releases cleanly.
//  aresetn low during WRESP -> all outputs 0 next cycle, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/axi_lite_cmd_master_pkg.sv
// ----------------------------------------------------------------------------
// axi_lite_cmd_master_pkg
// Shared definitions for the AXI4-Lite command master: FSM state type and
// AXI response codes.
// ----------------------------------------------------------------------------
package axi_lite_cmd_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_WRESP = 3'd2,
    ST_RD    = 3'd3,
    ST_RDATA = 3'd4,
    ST_RSP   = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_EXOKAY  = 2'b01;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_DECERR  = 2'b11;
  // Reported on a watchdog abort; shares the DECERR code on the response port.
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  // States in which an AXI transaction is outstanding and the watchdog runs.
  function automatic logic is_busy(state_e s);
    return (s == ST_WR) || (s == ST_WRESP) || (s == ST_RD) || (s == ST_RDATA);
  endfunction

endpackage

// File: rtl/axi_lite_cmd_master_if.sv
// ----------------------------------------------------------------------------
// axi_lite_cmd_master_if
// AXI4-Lite bus bundle between the command master and a register slave.
// Ports (signals):
//   AW: awaddr, awvalid, awready     W: wdata, wstrb, wvalid, wready
//   B : bresp, bvalid, bready        AR: araddr, arvalid, arready
//   R : rdata, rresp, rvalid, rready
// Modports: master (drives addresses/data/valids/readies), slave (mirror).
// ----------------------------------------------------------------------------
interface axi_lite_cmd_master_if #(
  parameter int unsigned ADDRESS_SIZE = 32,
  parameter int unsigned DATA_SIZE    = 32
) ();

  logic [ADDRESS_SIZE-1:0] awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_SIZE-1:0]    wdata;
  logic [DATA_SIZE/8-1:0]  wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDRESS_SIZE-1:0] araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_SIZE-1:0]    rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_cmd_master.sv
// ----------------------------------------------------------------------------
// axi_lite_cmd_master
// Turns one-at-a-time register commands into single AXI4-Lite read or write
// transactions and returns one response per command. A per-transaction
// watchdog aborts a transaction the slave never completes.
// Ports:
//   aclk, aresetn           clock, synchronous active-low reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_write, cmd_addr, cmd_wdata, cmd_wstrb   command payload
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata, rsp_resp, rsp_timeout            response payload
//   m_axi                   AXI4-Lite master bus (interface, master modport)
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module axi_lite_cmd_master
  import axi_lite_cmd_master_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE   = 32,
  parameter int unsigned DATA_SIZE      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDRESS_SIZE-1:0] cmd_addr,
  input  logic [DATA_SIZE-1:0]    cmd_wdata,
  input  logic [DATA_SIZE/8-1:0]  cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_SIZE-1:0]    rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  axi_lite_cmd_master_if.master   m_axi
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic             WD_ON    = (TIMEOUT_CYCLES != 0);

  state_e                  state_q,       state_d;
  logic                    cmd_ready_q,   cmd_ready_d;
  logic [ADDRESS_SIZE-1:0] addr_q,        addr_d;
  logic [DATA_SIZE-1:0]    wdata_q,       wdata_d;
  logic [DATA_SIZE/8-1:0]  wstrb_q,       wstrb_d;
  logic                    awvalid_q,     awvalid_d;
  logic                    wvalid_q,      wvalid_d;
  logic                    bready_q,      bready_d;
  logic                    arvalid_q,     arvalid_d;
  logic                    rready_q,      rready_d;
  logic                    rsp_valid_q,   rsp_valid_d;
  logic [DATA_SIZE-1:0]    rsp_rdata_q,   rsp_rdata_d;
  logic [1:0]              rsp_resp_q,    rsp_resp_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]        cnt_q,         cnt_d;

  logic expire;
  logic abort;

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    abort         = 1'b0;

    // Expiry fires on the cycle whose count reaches the limit; any handshake
    // completing on that same cycle is evaluated first and takes priority.
    expire = WD_ON && (cnt_q >= CNT_LAST);

    if (is_busy(state_q) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d   = 1'b0;
          addr_d        = cmd_addr;
          cnt_d         = '0;
          rsp_rdata_d   = '0;
          rsp_resp_d    = RESP_OKAY;
          rsp_timeout_d = 1'b0;
          if (cmd_write) begin
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD;
          end
        end
      end

      ST_WR: begin
        // AW and W retire independently; each valid falls after its own handshake.
        awvalid_d = awvalid_q && !m_axi.awready;
        wvalid_d  = wvalid_q  && !m_axi.wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WRESP;
        end else if (expire) begin
          abort = 1'b1;
        end
      end

      ST_WRESP: begin
        if (bready_q && m_axi.bvalid) begin
          bready_d    = 1'b0;
          rsp_resp_d  = m_axi.bresp;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end else if (expire) begin
          abort = 1'b1;
        end
      end

      ST_RD: begin
        if (arvalid_q && m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RDATA;
        end else if (expire) begin
          abort = 1'b1;
        end
      end

      ST_RDATA: begin
        if (rready_q && m_axi.rvalid) begin
          rready_d    = 1'b0;
          rsp_rdata_d = m_axi.rdata;
          rsp_resp_d  = m_axi.rresp;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end else if (expire) begin
          abort = 1'b1;
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_rdata_d   = '0;
      rsp_resp_d    = RESP_TIMEOUT;
      rsp_timeout_d = 1'b1;
      rsp_valid_d   = 1'b1;
      state_d       = ST_RSP;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// ----------------------------------------------------------------------------
// tb_axi_lite_cmd_master
// Drives commands into axi_lite_cmd_master against a behavioural AXI4-Lite
// slave with programmable per-channel delays; expected responses come from a
// word-addressed reference memory and cycle-count formulas.
// ----------------------------------------------------------------------------
module tb_axi_lite_cmd_master;
  import axi_lite_cmd_master_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;

  axi_lite_cmd_master_if #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) m_axi ();

  axi_lite_cmd_master #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .TIMEOUT_CYCLES(TO)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_wstrb   (cmd_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_resp    (rsp_resp),
    .rsp_timeout (rsp_timeout),
    .m_axi       (m_axi)
  );

  always #5 aclk = ~aclk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
  endtask

  // ---------------- reference memory ----------------
  logic [31:0] model_mem [bit [31:0]];
  logic [31:0] slave_mem [bit [31:0]];

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] data, logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : 32'h0;
  endfunction

  // ---------------- behavioural slave + bus monitor ----------------
  int unsigned aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [1:0]  b_resp_cfg, r_resp_cfg;
  int unsigned aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic        aw_got, w_got, ar_got;
  logic        aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  int unsigned aw_hi, w_hi, ar_hi, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  int unsigned proto_err = 0;
  logic        prev_rst = 1'b0;
  logic        prev_awv, prev_awr, prev_wv, prev_wr, prev_arv, prev_arr;
  logic [31:0] prev_awaddr, prev_wdata, prev_araddr;
  logic [3:0]  prev_wstrb;

  always @(negedge aclk) begin
    // A pending valid may only disappear through a watchdog abort; payload must hold.
    if (aresetn && prev_rst) begin
      if (prev_awv && !prev_awr && (m_axi.awvalid !== 1'b1) && !rsp_timeout) proto_err++;
      if (prev_wv  && !prev_wr  && (m_axi.wvalid  !== 1'b1) && !rsp_timeout) proto_err++;
      if (prev_arv && !prev_arr && (m_axi.arvalid !== 1'b1) && !rsp_timeout) proto_err++;
      if (prev_awv && !prev_awr && m_axi.awvalid && (m_axi.awaddr !== prev_awaddr)) proto_err++;
      if (prev_wv  && !prev_wr  && m_axi.wvalid  &&
          ((m_axi.wdata !== prev_wdata) || (m_axi.wstrb !== prev_wstrb))) proto_err++;
      if (prev_arv && !prev_arr && m_axi.arvalid && (m_axi.araddr !== prev_araddr)) proto_err++;
    end
    if (m_axi.awvalid === 1'b1) aw_hi++;
    if (m_axi.wvalid  === 1'b1) w_hi++;
    if (m_axi.arvalid === 1'b1) ar_hi++;

    if (!aresetn) begin
      m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.bvalid = 1'b0; m_axi.bresp = 2'b00;
      m_axi.arready = 1'b0; m_axi.rvalid = 1'b0; m_axi.rdata = '0;    m_axi.rresp = 2'b00;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0;
      aw_fire = 1'b0; w_fire = 1'b0; b_fire = 1'b0; ar_fire = 1'b0; r_fire = 1'b0;
    end else begin
      // Handshakes decided at the previous negedge completed at the posedge just past.
      if (aw_fire) begin aw_got = 1'b1; aw_cnt = 0; end
      if (w_fire)  begin w_got  = 1'b1; w_cnt  = 0; end
      if (ar_fire) begin ar_got = 1'b1; ar_cnt = 0; end
      if (b_fire) begin
        m_axi.bvalid = 1'b0;
        slave_mem[s_awaddr] = merge(slave_mem.exists(s_awaddr) ? slave_mem[s_awaddr] : 32'h0,
                                    s_wdata, s_wstrb);
        aw_got = 1'b0; w_got = 1'b0; b_cnt = 0;
      end
      if (r_fire) begin
        m_axi.rvalid = 1'b0; ar_got = 1'b0; r_cnt = 0;
      end

      m_axi.awready = 1'b0;
      if (m_axi.awvalid && !aw_got) begin
        if (aw_cnt >= aw_dly) m_axi.awready = 1'b1;
        aw_cnt++;
      end
      m_axi.wready = 1'b0;
      if (m_axi.wvalid && !w_got) begin
        if (w_cnt >= w_dly) m_axi.wready = 1'b1;
        w_cnt++;
      end
      m_axi.arready = 1'b0;
      if (m_axi.arvalid && !ar_got) begin
        if (ar_cnt >= ar_dly) m_axi.arready = 1'b1;
        ar_cnt++;
      end
      if (aw_got && w_got && !m_axi.bvalid) begin
        if (b_cnt >= b_dly) begin m_axi.bvalid = 1'b1; m_axi.bresp = b_resp_cfg; end
        else b_cnt++;
      end
      if (ar_got && !m_axi.rvalid) begin
        if (r_cnt >= r_dly) begin
          m_axi.rvalid = 1'b1;
          m_axi.rdata  = slave_mem.exists(s_araddr) ? slave_mem[s_araddr] : 32'h0;
          m_axi.rresp  = r_resp_cfg;
        end else r_cnt++;
      end

      aw_fire = m_axi.awvalid && m_axi.awready;
      w_fire  = m_axi.wvalid  && m_axi.wready;
      ar_fire = m_axi.arvalid && m_axi.arready;
      b_fire  = m_axi.bvalid  && m_axi.bready;
      r_fire  = m_axi.rvalid  && m_axi.rready;
      if (aw_fire) begin s_awaddr = m_axi.awaddr; aw_hs++; end
      if (w_fire)  begin s_wdata = m_axi.wdata; s_wstrb = m_axi.wstrb; w_hs++; end
      if (ar_fire) begin s_araddr = m_axi.araddr; ar_hs++; end
      if (b_fire)  b_hs++;
      if (r_fire)  r_hs++;
    end

    prev_rst = aresetn;
    prev_awv = m_axi.awvalid; prev_awr = m_axi.awready; prev_awaddr = m_axi.awaddr;
    prev_wv  = m_axi.wvalid;  prev_wr  = m_axi.wready;  prev_wdata = m_axi.wdata;
    prev_wstrb = m_axi.wstrb;
    prev_arv = m_axi.arvalid; prev_arr = m_axi.arready; prev_araddr = m_axi.araddr;
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_slave(input int unsigned a, input int unsigned w, input int unsigned b,
                           input int unsigned ar, input int unsigned r,
                           input logic [1:0] br, input logic [1:0] rr);
    aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    b_resp_cfg = br; r_resp_cfg = rr;
    aw_hi = 0; w_hi = 0; ar_hi = 0; aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    repeat (3) tick();
    aresetn = 1'b1;
    tick();
  endtask

  // Issue one command, wait for its response, optionally stall rsp_ready while
  // offering a stray command, then complete the response handshake.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int unsigned hold,
                         output int unsigned lat, output logic [31:0] rdata,
                         output logic [1:0] resp, output logic to,
                         output int unsigned stall_bad, output logic [1:0] post);
    int unsigned w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin tick(); w++; end
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 200) begin tick(); lat++; end
    rdata = rsp_rdata; resp = rsp_resp; to = rsp_timeout;
    stall_bad = 0;
    for (int i = 0; i < int'(hold); i++) begin
      cmd_valid = 1'b1; cmd_write = 1'($urandom);
      tick();
      if (rsp_valid !== 1'b1 || rsp_rdata !== rdata || rsp_resp !== resp ||
          rsp_timeout !== to || cmd_ready !== 1'b0 ||
          m_axi.awvalid !== 1'b0 || m_axi.wvalid !== 1'b0 || m_axi.arvalid !== 1'b0)
        stall_bad++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    post = {rsp_valid, cmd_ready};
  endtask

  // ---------------- directed + random sequence ----------------
  int unsigned lat, stall, exp_lat, w;
  logic [31:0] rd, data, addr;
  logic [1:0]  resp, br, rr, post;
  logic [3:0]  strb;
  logic        to, wr;
  logic [1:0]  resp_tab [4];

  initial begin
    resp_tab[0] = RESP_OKAY; resp_tab[1] = RESP_EXOKAY;
    resp_tab[2] = RESP_SLVERR; resp_tab[3] = RESP_DECERR;
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    set_slave(0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY);
    repeat (3) tick();

    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_rsp_payload", {rsp_rdata, rsp_resp}, 0);
    chk("rst_axi_ctrl", {m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready}, 0);
    chk("rst_axi_addr", {m_axi.awaddr, m_axi.araddr}, 0);
    aresetn = 1'b1;
    tick();
    chk("cmd_ready_after_release", cmd_ready, 1);

    // Minimum-latency write then read-back.
    set_slave(0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY);
    run_cmd(1'b1, 32'h0, 32'hDEADBEEF, 4'hF, 0, lat, rd, resp, to, stall, post);
    model_mem[32'h0] = merge(model_read(32'h0), 32'hDEADBEEF, 4'hF);
    chk("wr0_latency", lat, 3);
    chk("wr0_resp", {to, resp, rd}, 0);
    chk("wr0_beats", {aw_hs[7:0], w_hs[7:0], b_hs[7:0]}, 24'h010101);
    chk("wr0_post", post, 2'b01);
    run_cmd(1'b0, 32'h0, 32'h0, 4'h0, 0, lat, rd, resp, to, stall, post);
    chk("rd0_latency", lat, 3);
    chk("rd0_data", rd, 32'hDEADBEEF);
    chk("rd0_resp", {to, resp}, 0);

    // awready held off for 4 cycles, wready immediate.
    set_slave(4, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY);
    data = $urandom; strb = 4'b1010;
    run_cmd(1'b1, 32'h4, data, strb, 0, lat, rd, resp, to, stall, post);
    model_mem[32'h4] = merge(model_read(32'h4), data, strb);
    chk("awdly_wvalid_cycles", w_hi, 1);
    chk("awdly_awvalid_cycles", aw_hi, 5);
    chk("awdly_bresp_count", b_hs, 1);
    chk("awdly_latency", lat, 4 + 3);

    // rvalid held off for 7 cycles with SLVERR.
    set_slave(0, 0, 0, 0, 7, RESP_OKAY, RESP_SLVERR);
    run_cmd(1'b0, 32'h4, 32'h0, 4'h0, 0, lat, rd, resp, to, stall, post);
    chk("rdly_data", rd, model_read(32'h4));
    chk("rdly_resp", resp, 2'b10);
    chk("rdly_timeout", to, 0);
    chk("rdly_latency", lat, 7 + 3);

    // Response stalled 10 cycles with a stray command offered meanwhile.
    set_slave(0, 0, 0, 0, 0, RESP_EXOKAY, RESP_OKAY);
    data = $urandom;
    run_cmd(1'b1, 32'h8, data, 4'hF, 10, lat, rd, resp, to, stall, post);
    model_mem[32'h8] = merge(model_read(32'h8), data, 4'hF);
    chk("stall_stable", stall, 0);
    chk("stall_resp", resp, RESP_EXOKAY);
    chk("stall_post", post, 2'b01);
    chk("stall_single_txn", {aw_hs[7:0], ar_hs[7:0]}, 16'h0100);

    // Randomised commands with random delays, responses and stalls.
    for (int n = 0; n < 24; n++) begin
      int unsigned a, ww, b, ar, r, hold;
      a = $urandom_range(0, 4); ww = $urandom_range(0, 4); b = $urandom_range(0, 4);
      ar = $urandom_range(0, 4); r = $urandom_range(0, 4); hold = $urandom_range(0, 3);
      br = resp_tab[$urandom_range(0, 3)]; rr = resp_tab[$urandom_range(0, 3)];
      set_slave(a, ww, b, ar, r, br, rr);
      addr = ($urandom_range(0, 4) == 4) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 3) * 4);
      data = $urandom; strb = 4'($urandom); wr = 1'($urandom);
      run_cmd(wr, addr, data, strb, hold, lat, rd, resp, to, stall, post);
      if (wr) begin
        model_mem[addr] = merge(model_read(addr), data, strb);
        exp_lat = ((a > ww) ? a : ww) + b + 3;
        chk("rnd_wr_resp", {to, resp, rd}, {1'b0, br, 32'h0});
      end else begin
        exp_lat = ar + r + 3;
        chk("rnd_rd_resp", {to, resp, rd}, {1'b0, rr, model_read(addr)});
      end
      chk("rnd_latency", lat, exp_lat);
      chk("rnd_stall", {stall, post}, {32'h0, 2'b01});
    end

    // Address handshake on the last watchdog cycle wins over the timeout.
    set_slave(0, 0, 0, TO - 1, 0, RESP_OKAY, RESP_OKAY);
    run_cmd(1'b0, 32'h0, 32'h0, 4'h0, 0, lat, rd, resp, to, stall, post);
    chk("edge_no_timeout", {to, resp}, 0);
    chk("edge_data", rd, model_read(32'h0));
    chk("edge_latency", lat, TO - 1 + 3);

    // Slave never accepts the read address: watchdog abort.
    set_slave(0, 0, 0, 1000, 0, RESP_OKAY, RESP_OKAY);
    run_cmd(1'b0, 32'hC, 32'h0, 4'h0, 0, lat, rd, resp, to, stall, post);
    chk("to_arvalid_cycles", ar_hi, TO);
    chk("to_resp", resp, 2'b11);
    chk("to_flag", to, 1);
    chk("to_rdata", rd, 0);
    chk("to_latency", lat, TO + 1);
    do_reset();

    // Reset asserted while waiting for the write response.
    set_slave(0, 0, 1000, 0, 0, RESP_OKAY, RESP_OKAY);
    w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin tick(); w++; end
    cmd_write = 1'b1; cmd_addr = 32'h8; cmd_wdata = 32'h1234_5678; cmd_wstrb = 4'hF;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    w = 0;
    while (m_axi.bready !== 1'b1 && w < 30) begin tick(); w++; end
    chk("wresp_reached", m_axi.bready, 1);
    aresetn = 1'b0;
    tick();
    chk("midrst_ctrl", {cmd_ready, rsp_valid, rsp_timeout, m_axi.awvalid, m_axi.wvalid,
                        m_axi.bready, m_axi.arvalid, m_axi.rready}, 0);
    chk("midrst_regs", {rsp_rdata, rsp_resp, m_axi.awaddr, m_axi.wdata, m_axi.wstrb}, 0);
    tick();
    aresetn = 1'b1;
    tick();
    chk("midrst_release", {cmd_ready, rsp_valid}, 2'b10);

    // Bus usable again after reset.
    set_slave(0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY);
    run_cmd(1'b0, 32'h8, 32'h0, 4'h0, 0, lat, rd, resp, to, stall, post);
    chk("post_rst_read", {to, resp, rd}, {3'b000, model_read(32'h8)});
    chk("post_rst_latency", lat, 3);

    chk("protocol_rules", proto_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
